// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, source enum and entry record for the writeback stage
package wb_stage_pkg;
  localparam int WB_DW = 8;
  localparam int WB_RFW = 2;
  typedef enum logic {SRC_ALU, SRC_LD} src_e;
  typedef struct packed {
    logic [WB_RFW-1:0] rd;
    logic [WB_DW-1:0]  data;
  } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order shift FIFO of writeback entries with a per-slot valid view
module wb_fifo import wb_stage_pkg::*; #(
  parameter type T = wb_entry,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  T                 din,
  output T                 dout,
  output logic             full,
  output logic             empty,
  output T                 mem [DEPTH],
  output logic [DEPTH-1:0] vld
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] wr_idx;
  // a simultaneous pop shifts the queue, so the push lands one slot lower
  assign wr_idx = cnt - CW'(pop);
  assign dout = mem[0];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else begin
      cnt <= cnt + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (pop) mem[i] <= mem[(i + 1) % DEPTH];
        if (push && wr_idx == CW'(i)) mem[i] <= din;
      end
    end
  end
  always_comb begin
    vld = '0;
    for (int i = 0; i < DEPTH; i++) vld[i] = cnt > CW'(i);
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: round-robin writeback arbiter that buffers ALU/load results in order
// and owns the register file write port.
module wb_stage import wb_stage_pkg::*; #(
  parameter int DW = WB_DW,
  parameter int RFW = WB_RFW,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RFW-1:0]    alu_rd,
  input  logic [DW-1:0]     alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [RFW-1:0]    ld_rd,
  input  logic [DW-1:0]     ld_data,
  input  logic              stall,
  output logic              rf_we,
  output logic [RFW-1:0]    rf_wr_address,
  output logic [DW-1:0]     rf_wr_data,
  output logic [2**RFW-1:0] busy_mask
);
  typedef struct packed {
    logic [RFW-1:0] rd;
    logic [DW-1:0]  data;
  } entry_t;
  entry_t out_q, in_e, head;
  entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic out_valid, retire, space, grant_alu, grant_ld, acc, store;
  logic load_out, pop, push, bypass, full, empty;
  src_e last_grant;
  assign retire = out_valid & ~stall;
  assign space = ~(out_valid & full) | retire;
  assign grant_ld = ld_valid & (~alu_valid | last_grant == SRC_ALU);
  assign grant_alu = alu_valid & ~grant_ld;
  assign alu_ready = rst_n & space & grant_alu;
  assign ld_ready = rst_n & space & grant_ld;
  assign acc = alu_ready | ld_ready;
  assign in_e = grant_ld ? entry_t'{ld_rd, ld_data} : entry_t'{alu_rd, alu_data};
  // writes to register 0 are consumed here and never occupy a slot
  assign store = acc & (in_e.rd != '0);
  assign load_out = ~out_valid | retire;
  assign pop = load_out & ~empty;
  assign bypass = load_out & empty & store;
  assign push = store & ~bypass;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q <= '0;
      last_grant <= SRC_ALU;
    end else begin
      if (load_out) begin
        out_valid <= pop | bypass;
        if (pop) out_q <= head;
        else if (bypass) out_q <= in_e;
      end
      if (acc) last_grant <= grant_ld ? SRC_LD : SRC_ALU;
    end
  end
  assign rf_we = retire;
  assign rf_wr_address = out_q.rd;
  assign rf_wr_data = out_q.data;
  always_comb begin
    busy_mask = '0;
    if (out_valid) busy_mask[out_q.rd] = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (vld[i]) busy_mask[mem[i].rd] = 1'b1;
  end
  wb_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(in_e),
    .dout(head),
    .full(full),
    .empty(empty),
    .mem(mem),
    .vld(vld)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven directed checks of wb_stage plus stall and reset sequences
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid, ld_valid, stall;
  logic [1:0] alu_rd, ld_rd, rf_wr_address;
  logic [7:0] alu_data, ld_data, rf_wr_data;
  logic alu_ready, ld_ready, rf_we;
  logic [3:0] busy_mask;
  logic [7:0] rf [4] = '{default: 8'h00};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (rf_we) rf[rf_wr_address] <= rf_wr_data;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .stall(stall), .rf_we(rf_we), .rf_wr_address(rf_wr_address),
    .rf_wr_data(rf_wr_data), .busy_mask(busy_mask)
  );

  typedef struct {
    logic av; logic [1:0] ard; logic [7:0] adat;
    logic lv; logic [1:0] lrd; logic [7:0] ldat;
    logic st;
    logic ear; logic elr; logic ewe; logic [1:0] eaddr; logic [7:0] edat; logic [3:0] ebusy;
  } vec_t;
  vec_t tbl [14];

  function automatic vec_t mk(logic av, logic [1:0] ard, logic [7:0] adat,
                              logic lv, logic [1:0] lrd, logic [7:0] ldat, logic st,
                              logic ear, logic elr, logic ewe, logic [1:0] eaddr,
                              logic [7:0] edat, logic [3:0] ebusy);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.st = st;
    v.ear = ear; v.elr = elr; v.ewe = ewe; v.eaddr = eaddr; v.edat = edat; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [1:0] ard, logic [7:0] adat,
                       logic lv, logic [1:0] lrd, logic [7:0] ldat, logic st);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat; stall = st;
  endtask

  task automatic outs(string tag, logic ear, logic elr, logic ewe,
                      logic [1:0] eaddr, logic [7:0] edat, logic [3:0] ebusy);
    chk({tag, ".alu_ready"}, alu_ready, ear);
    chk({tag, ".ld_ready"}, ld_ready, elr);
    chk({tag, ".rf_we"}, rf_we, ewe);
    if (ewe) begin
      chk({tag, ".addr"}, rf_wr_address, eaddr);
      chk({tag, ".data"}, rf_wr_data, edat);
    end
    chk({tag, ".busy"}, busy_mask, ebusy);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic rdy;
    logic [1:0] rds [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] dat [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    tbl[0]  = mk(1, 2, 8'h5A, 0, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 4'b0000);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 2, 8'h5A, 4'b0100);
    tbl[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 4'b0000);
    tbl[3]  = mk(1, 1, 8'h11, 1, 3, 8'h33, 0,  0, 1, 0, 0, 8'h00, 4'b0000);
    tbl[4]  = mk(1, 1, 8'h11, 1, 3, 8'h33, 0,  1, 0, 1, 3, 8'h33, 4'b1000);
    tbl[5]  = mk(1, 1, 8'h11, 1, 3, 8'h33, 0,  0, 1, 1, 1, 8'h11, 4'b0010);
    tbl[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 3, 8'h33, 4'b1000);
    tbl[7]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 4'b0000);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0, 8'hFF, 0,  0, 1, 0, 0, 8'h00, 4'b0000);
    tbl[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 4'b0000);
    tbl[10] = mk(1, 1, 8'h01, 0, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 4'b0000);
    tbl[11] = mk(1, 1, 8'h02, 0, 0, 8'h00, 0,  1, 0, 1, 1, 8'h01, 4'b0010);
    tbl[12] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 1, 8'h02, 4'b0010);
    tbl[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 4'b0000);

    drive(1, 2'd1, 8'h77, 0, 0, 8'h00, 0);
    rst_n = 1'b0;
    cyc_end();
    @(negedge clk);
    outs("reset", 0, 0, 0, 0, 8'h00, 4'b0000);
    chk("reset.addr", rf_wr_address, 0);
    chk("reset.data", rf_wr_data, 0);
    cyc_end();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat, tbl[i].st);
      @(negedge clk);
      outs($sformatf("vec%0d", i), tbl[i].ear, tbl[i].elr, tbl[i].ewe, tbl[i].eaddr,
           tbl[i].edat, tbl[i].ebusy);
      cyc_end();
    end
    chk("rf1_last_write", rf[1], 8'h02);
    chk("rf0_untouched", rf[0], 8'h00);

    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, rds[k], dat[k], 0, 0, 8'h00, 1);
      @(negedge clk);
      rdy = alu_ready;
      chk($sformatf("stall%0d.alu_ready", c), alu_ready, c < 3);
      chk($sformatf("stall%0d.rf_we", c), rf_we, 0);
      if (c == 4) chk("stall.busy", busy_mask, 4'b1110);
      cyc_end();
      if (rdy) k++;
    end
    chk("stall.accepted", k, 3);
    drive(1, rds[3], dat[3], 0, 0, 8'h00, 0);
    @(negedge clk);
    outs("release0", 1, 0, 1, 2'd1, 8'hA1, 4'b1110);
    cyc_end();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("release%0d.rf_we", c), rf_we, 1);
      chk($sformatf("release%0d.addr", c), rf_wr_address, rds[c]);
      chk($sformatf("release%0d.data", c), rf_wr_data, dat[c]);
      cyc_end();
    end
    @(negedge clk);
    outs("drained", 0, 0, 0, 0, 8'h00, 4'b0000);
    cyc_end();

    drive(1, 2'd1, 8'hB1, 0, 0, 8'h00, 1);
    cyc_end();
    drive(1, 2'd2, 8'hB2, 0, 0, 8'h00, 1);
    cyc_end();
    drive(0, 0, 8'h00, 1, 2'd3, 8'hB3, 1);
    @(negedge clk);
    chk("fill.ld_ready", ld_ready, 1);
    cyc_end();
    drive(1, 2'd1, 8'hC1, 1, 2'd2, 8'hC2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_low.alu_ready", alu_ready, 0);
    chk("rst_low.ld_ready", ld_ready, 0);
    cyc_end();
    @(negedge clk);
    outs("rst_after", 0, 0, 0, 0, 8'h00, 4'b0000);
    cyc_end();
    rst_n = 1'b1;
    @(negedge clk);
    outs("tie_after_rst", 0, 1, 0, 0, 8'h00, 4'b0000);
    cyc_end();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    outs("tie_write", 0, 0, 1, 2'd2, 8'hC2, 4'b0100);
    cyc_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
